scan_test_controller: RTL and testbench
=======================================

// Module: scan_test_controller
// PURPOSE
//  Sequences the scan chain of the 3-output DFT schematic block through full
//  test patterns: serial shift-in, one capture clock, then serial shift-out
//  with on-the-fly comparison against expected responses.
//  Sits between the pattern source (testbench or BIST ROM) and the chain's
//  scan_en/scan_in/scan_out pins. Reports pass/fail and a failing-pattern count.
// PARAMETERS
//  CHAIN_LEN     3   number of scan flops in the chain (>=1)
//  NUM_PATTERNS  8   patterns applied per run (>=1)
//  CNT_W         8   width of pattern index and fail counter
// PORTS
//  clk         in   1          single system/test clock, rising edge
//  rst_n       in   1          asynchronous, active-low reset
//  start       in   1          1-cycle pulse; starts a run when IDLE
//  pat_valid   in   1          pat_data/exp_data valid
//  pat_ready   out  1          controller accepts pattern this cycle
//  pat_data    in   CHAIN_LEN  stimulus vector; bit 0 shifted first
//  exp_data    in   CHAIN_LEN  expected capture response; bit 0 unloaded first
//  scan_en     out  1          1 = chain shifts, 0 = functional capture
//  scan_in     out  1          serial data into chain
//  scan_out    in   1          serial data from chain tail
//  busy        out  1          run in progress
//  done        out  1          1-cycle pulse at end of run
//  fail        out  1          sticky: any mismatch this run
//  fail_count  out  CNT_W      number of patterns with >=1 mismatch (saturating)
//  pat_index   out  CNT_W      index of pattern currently being applied
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; scan_en=0, scan_in=0, pat_ready=0,
//   busy=0, done=0, fail=0, fail_count=0, pat_index=0, bit counter=0.
//  FSM states: IDLE, LOAD, SHIFT_IN, CAPTURE, SHIFT_OUT, FINISH.
//  IDLE: start=1 -> LOAD, clear fail/fail_count/pat_index. start ignored when busy.
//  LOAD: pat_ready=1; on pat_valid&&pat_ready latch pat_data, exp_data into
//   local registers -> SHIFT_IN, bit counter=0. Waits indefinitely otherwise.
//  SHIFT_IN: CHAIN_LEN cycles; scan_en=1, scan_in=pat_reg[k] in cycle k.
//   After cycle CHAIN_LEN-1 -> CAPTURE.
//  CAPTURE: exactly 1 cycle, scan_en=0, scan_in=0 -> SHIFT_OUT, counter=0.
//  SHIFT_OUT: CHAIN_LEN cycles; scan_en=1, scan_in=0; scan_out sampled at
//   rising edge ending cycle k, compared with exp_reg[k]; mismatch sets a
//   per-pattern flag. On last bit: if flag (incl. this bit) then fail=1,
//   fail_count+=1 (hold at all-ones). Then if pat_index==NUM_PATTERNS-1
//   -> FINISH else pat_index+=1 -> LOAD.
//  FINISH: done=1 for one cycle, scan_en=0 -> IDLE. fail/fail_count/pat_index
//   hold until next start.
//  busy=1 in every state except IDLE.
//  Latency per pattern (pat_valid held high): 1 + 2*CHAIN_LEN + 1 cycles.
//  Outputs registered; pattern registers only change in LOAD handshake.
//  rst_n low mid-run aborts immediately to reset values; no done pulse.
//  CHAIN_LEN=1: SHIFT_IN/SHIFT_OUT each last one cycle.
// STRUCTURE
//  Package scan_pkg: state enum (3-bit encoding), default CHAIN_LEN.
//  Bit counter width $clog2(CHAIN_LEN+1).
//  One sub-module natural: scan_shift_cnt (bit counter with terminal flag),
//  reused for SHIFT_IN and SHIFT_OUT; comparator/flag logic stays inline.
// TESTING
//  1 Reset mid-SHIFT_IN (rst_n low 1 cycle) -> all outputs 0, state IDLE, no done.
//  2 CHAIN_LEN=3, pat 3'b101, exp 3'b110, chain model returns exp ->
//    scan_in 1,0,1 then scan_en=0 one cycle; fail=0, done after 8 patterns.
//  3 Model flips bit 2 on pattern 4 only -> fail=1, fail_count=1, pat_index=7 at done.
//  4 pat_valid withheld 5 cycles in LOAD -> scan_en stays 0, pat_ready held 1,
//    run resumes unchanged; total run cycles increase by exactly 5.
//  5 start pulsed while busy -> ignored; new start after done clears fail/count.
//  6 Every pattern mismatches with CNT_W=2, NUM_PATTERNS=5 -> fail_count saturates at 3.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and defaults for the scan test controller.
package scan_pkg;

  localparam int DEF_CHAIN_LEN = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SHIFT_IN  = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_SHIFT_OUT = 3'd4,
    ST_FINISH    = 3'd5
  } scan_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/scan_shift_cnt.sv
// Bit counter for the shift phases; cnt_nxt is exposed so the parent can
// register its serial output one cycle ahead of the state it belongs to.
module scan_shift_cnt #(
  parameter int LEN = 3,
  parameter int W   = $clog2(LEN + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_nxt,
  output logic         last
);

  always_comb begin
    cnt_nxt = cnt;
    if (clr)     cnt_nxt = '0;
    else if (en) cnt_nxt = cnt + 1'b1;
  end

  assign last = (cnt == W'(LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

endmodule

// File: rtl/scan_test_controller.sv
// Scan chain sequencer: load pattern, shift in, capture, shift out and compare.
//
//   state        | meaning
//   ST_IDLE      | waiting for start
//   ST_LOAD      | pat_ready high, waiting for a pattern handshake
//   ST_SHIFT_IN  | shifting pat_reg into the chain, bit 0 first
//   ST_CAPTURE   | one functional clock with scan_en low
//   ST_SHIFT_OUT | unloading the chain and comparing against exp_reg
//   ST_FINISH    | one-cycle done pulse, then back to idle
module scan_test_controller
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN    = DEF_CHAIN_LEN,
  parameter int NUM_PATTERNS = 8,
  parameter int CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_data,
  input  logic [CHAIN_LEN-1:0] exp_data,
  output logic                 scan_en,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [CNT_W-1:0]     fail_count,
  output logic [CNT_W-1:0]     pat_index
);

  localparam int BIT_W = $clog2(CHAIN_LEN + 1);
  // The internal pattern counter must reach NUM_PATTERNS-1 even when the
  // reported index is narrower; pat_index shows its low CNT_W bits.
  localparam int IDX_W = max_int(CNT_W, $clog2(NUM_PATTERNS + 1));

  scan_state_e          state_q, state_nxt;
  logic [CHAIN_LEN-1:0] pat_reg, exp_reg, pat_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [IDX_W-1:0]     pat_cnt;
  logic                 bit_last, cnt_clr, cnt_en;
  logic                 load_hs, mism, pat_fail_q, last_pat, scan_in_nxt;

  scan_shift_cnt #(
    .LEN (CHAIN_LEN),
    .W   (BIT_W)
  ) u_bit_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .cnt     (bit_cnt),
    .cnt_nxt (bit_cnt_nxt),
    .last    (bit_last)
  );

  assign load_hs  = pat_valid && pat_ready;
  assign last_pat = (pat_cnt == IDX_W'(NUM_PATTERNS - 1));
  assign mism     = (state_q == ST_SHIFT_OUT) && (scan_out != exp_reg[bit_cnt]);
  assign pat_nxt  = load_hs ? pat_data : pat_reg;
  assign pat_index = pat_cnt[CNT_W-1:0];

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:      if (start) state_nxt = ST_LOAD;
      ST_LOAD:      if (load_hs) state_nxt = ST_SHIFT_IN;
      ST_SHIFT_IN:  if (bit_last) state_nxt = ST_CAPTURE;
      ST_CAPTURE:   state_nxt = ST_SHIFT_OUT;
      ST_SHIFT_OUT: if (bit_last) state_nxt = last_pat ? ST_FINISH : ST_LOAD;
      ST_FINISH:    state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Every state change restarts the bit count, so each shift phase starts at 0.
  always_comb begin
    cnt_clr     = (state_nxt != state_q);
    cnt_en      = (state_q == ST_SHIFT_IN) || (state_q == ST_SHIFT_OUT);
    scan_in_nxt = (state_nxt == ST_SHIFT_IN) && pat_nxt[bit_cnt_nxt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pat_reg    <= '0;
      exp_reg    <= '0;
      pat_fail_q <= 1'b0;
      fail       <= 1'b0;
      fail_count <= '0;
      pat_cnt    <= '0;
      pat_ready  <= 1'b0;
      scan_en    <= 1'b0;
      scan_in    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q <= state_nxt;

      if (state_q == ST_IDLE && start) begin
        fail       <= 1'b0;
        fail_count <= '0;
        pat_cnt    <= '0;
      end

      if (load_hs) begin
        pat_reg    <= pat_data;
        exp_reg    <= exp_data;
        pat_fail_q <= 1'b0;
      end

      if (state_q == ST_SHIFT_OUT) begin
        if (mism) pat_fail_q <= 1'b1;
        if (bit_last) begin
          if (pat_fail_q || mism) begin
            fail <= 1'b1;
            if (fail_count != '1) fail_count <= fail_count + 1'b1;
          end
          if (!last_pat) pat_cnt <= pat_cnt + 1'b1;
        end
      end

      // Outputs are registered from the next state so they line up with it.
      pat_ready <= (state_nxt == ST_LOAD);
      scan_en   <= (state_nxt == ST_SHIFT_IN) || (state_nxt == ST_SHIFT_OUT);
      scan_in   <= scan_in_nxt;
      busy      <= (state_nxt != ST_IDLE);
      done      <= (state_nxt == ST_FINISH);
    end
  end

endmodule

// File: tb/tb_scan_test_controller.sv
// Bench for scan_test_controller: a behavioural scan chain plus a pattern
// source; a second narrow instance exercises fail_count saturation.
module tb_scan_test_controller;

  localparam int L   = 3;
  localparam int N   = 8;
  localparam int CW  = 8;
  localparam int SN  = 5;
  localparam int SCW = 2;
  localparam int PAT_CYC = 2 * L + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, pat_valid, pat_ready, scan_en, scan_in, scan_out;
  logic          busy, done, fail;
  logic [L-1:0]  pat_data, exp_data;
  logic [CW-1:0] fail_count, pat_index;

  logic           s_start, s_pat_ready, s_scan_en, s_scan_in, s_busy, s_done, s_fail;
  logic [L-1:0]   s_pat_data;
  logic [SCW-1:0] s_fail_count, s_pat_index;

  logic [L-1:0] chain, cur_pat, cur_resp;
  int cyc = 0;
  int n_total = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  scan_test_controller #(.CHAIN_LEN(L), .NUM_PATTERNS(N), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pat_valid(pat_valid),
    .pat_ready(pat_ready), .pat_data(pat_data), .exp_data(exp_data),
    .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out), .busy(busy),
    .done(done), .fail(fail), .fail_count(fail_count), .pat_index(pat_index)
  );

  // Every bit mismatches: chain tail stuck at 1, expected response all zero.
  scan_test_controller #(.CHAIN_LEN(L), .NUM_PATTERNS(SN), .CNT_W(SCW)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .pat_valid(1'b1),
    .pat_ready(s_pat_ready), .pat_data(s_pat_data), .exp_data('0),
    .scan_en(s_scan_en), .scan_in(s_scan_in), .scan_out(1'b1), .busy(s_busy),
    .done(s_done), .fail(s_fail), .fail_count(s_fail_count), .pat_index(s_pat_index)
  );

  // Behavioural chain: shifts toward the tail (bit 0), captures the response
  // of the pattern currently applied when scan_en is low during a capture.
  assign scan_out = chain[0];
  always @(posedge clk) begin
    if (scan_en) chain <= {scan_in, chain[L-1:1]};
    else if (busy && !pat_ready && !done) chain <= cur_resp;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at t=%0t", tag, got, want, $time);
    end
  endtask

  // The chain must hold the applied pattern just before capture.
  always @(negedge clk)
    if (rst_n && busy && !scan_en && !pat_ready && !done)
      check_eq("chain_load", 32'(chain), 32'(cur_pat));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: fixed 101/110, clean; mode 1: same, bit 2 flipped on pattern 4;
  // mode 2: random data and random faults.
  task automatic run_pass(input int mode, input int hold_pat, input int stray_pat);
    logic [L-1:0] p, e, flip;
    int exp_fails = 0;
    int t0, n;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("busy_after_start", 32'(busy), 1);
    t0 = cyc;
    for (int i = 0; i < N; i++) begin
      n = 0;
      while (!pat_ready && n < 40) begin tick(); n++; end
      check_eq("ready_wait", 32'(pat_ready), 1);
      check_eq("pat_index", 32'(pat_index), i);
      if (i == 0) begin
        check_eq("fail_clr", 32'(fail), 0);
        check_eq("count_clr", 32'(fail_count), 0);
      end
      if (i == hold_pat)
        repeat (5) begin
          tick();
          check_eq("hold_ready", 32'(pat_ready), 1);
          check_eq("hold_scan_en", 32'(scan_en), 0);
        end
      if (mode == 2) begin
        p = L'($urandom);
        e = L'($urandom);
        flip = ($urandom_range(0, 2) == 0) ? L'($urandom) : '0;
      end else begin
        p = 3'b101;
        e = 3'b110;
        flip = (mode == 1 && i == 4) ? 3'b100 : 3'b000;
      end
      if (flip != '0) exp_fails++;
      pat_data = p; exp_data = e; cur_pat = p; cur_resp = e ^ flip;
      pat_valid = 1'b1;
      tick();
      pat_valid = 1'b0;
      pat_data = L'($urandom);
      exp_data = L'($urandom);
      for (int k = 0; k < L; k++) begin
        check_eq("si_scan_en", 32'(scan_en), 1);
        check_eq("si_scan_in", 32'(scan_in), 32'(p[k]));
        if (i == stray_pat && k == 0) start = 1'b1;
        tick();
        start = 1'b0;
      end
      check_eq("cap_scan_en", 32'(scan_en), 0);
      check_eq("cap_scan_in", 32'(scan_in), 0);
      tick();
      for (int k = 0; k < L; k++) begin
        check_eq("so_scan_en", 32'(scan_en), 1);
        check_eq("so_scan_in", 32'(scan_in), 0);
        tick();
      end
    end
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    check_eq("done_seen", 32'(done), 1);
    check_eq("run_cycles", cyc - t0, N * PAT_CYC + ((hold_pat >= 0) ? 5 : 0));
    check_eq("fail", 32'(fail), (exp_fails != 0) ? 1 : 0);
    check_eq("fail_count", 32'(fail_count), (exp_fails > 255) ? 255 : exp_fails);
    check_eq("last_index", 32'(pat_index), N - 1);
    tick();
    check_eq("done_pulse", 32'(done), 0);
    check_eq("idle_busy", 32'(busy), 0);
    check_eq("fail_hold", 32'(fail), (exp_fails != 0) ? 1 : 0);
  endtask

  task automatic reset_mid_run();
    int n = 0;
    logic saw = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!pat_ready && n < 40) begin tick(); n++; end
    pat_data = 3'b111; exp_data = 3'b000; cur_pat = 3'b111; cur_resp = 3'b000;
    pat_valid = 1'b1;
    tick();
    pat_valid = 1'b0;
    tick();
    check_eq("rst_pre_scan_en", 32'(scan_en), 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_scan_en", 32'(scan_en), 0);
    check_eq("rst_scan_in", 32'(scan_in), 0);
    check_eq("rst_ready", 32'(pat_ready), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_fail", 32'(fail), 0);
    check_eq("rst_count", 32'(fail_count), 0);
    check_eq("rst_index", 32'(pat_index), 0);
    tick();
    rst_n = 1'b1;
    repeat (12) begin
      tick();
      saw = saw | done | busy;
    end
    check_eq("rst_no_done", 32'(saw), 0);
  endtask

  task automatic sat_run();
    int n = 0;
    int t0;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    t0 = cyc;
    while (!s_done && n < 200) begin tick(); n++; end
    check_eq("sat_done", 32'(s_done), 1);
    check_eq("sat_cycles", cyc - t0, SN * PAT_CYC);
    check_eq("sat_fail", 32'(s_fail), 1);
    check_eq("sat_count", 32'(s_fail_count), (1 << SCW) - 1);
    check_eq("sat_index", 32'(s_pat_index), (SN - 1) % (1 << SCW));
    tick();
    check_eq("sat_idle", 32'(s_busy), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pat_valid = 1'b0; pat_data = '0; exp_data = '0;
    s_start = 1'b0; s_pat_data = 3'b011;
    chain = '0; cur_pat = '0; cur_resp = '0;
    repeat (3) tick();
    check_eq("reset_busy", 32'(busy), 0);
    check_eq("reset_done", 32'(done), 0);
    check_eq("reset_scan_en", 32'(scan_en), 0);
    check_eq("reset_ready", 32'(pat_ready), 0);
    check_eq("reset_count", 32'(fail_count), 0);
    check_eq("reset_sat_count", 32'(s_fail_count), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    run_pass(0, -1, -1);
    run_pass(1, -1, -1);
    run_pass(2, 3, 2);
    reset_mid_run();
    run_pass(2, -1, 5);
    run_pass(2, 0, -1);
    sat_run();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
